// File: rtl/rv32i_fetch_stage.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_stage
//
// Instruction-fetch stage of rv32i_pipe. Owns the fetch PC, issues reads to a
// synchronous instruction memory (1-cycle read latency) and presents
// {pc, instruction} pairs to decode through a 2-entry skid buffer.
//
// Handshake (decode side): an instruction transfers on every rising clock
// edge where d_valid && d_ready are both 1. While d_valid=1 and no transfer
// happens, d_pc/d_inst hold their values. d_valid never depends on d_ready.
//
// Ports
//   clock           stage clock, all state changes on its rising edge
//   reset           synchronous, active-high reset
//   imem_en         read request this cycle
//   imem_addr       byte address of the request (always equals f_pc)
//   imem_rdata      instruction word, valid the cycle after an imem_en edge
//   redirect_valid  execute requests a PC change
//   redirect_pc     new fetch target
//   d_valid         instruction available to decode
//   d_ready         decode accepts this cycle
//   d_pc, d_inst    PC and word of the presented instruction (buffer head)
//   f_pc            current fetch PC
//   fault           sticky misaligned-fetch flag; it is the decoded FSM state
//                   (1 = HALT) and doubles as the state debug output
// ---------------------------------------------------------------------------
module rv32i_fetch_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_pc,
  output logic [31:0]     d_inst,
  output logic [XLEN-1:0] f_pc,
  output logic            fault
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  // FSM and fetch PC
  logic [0:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_epoch;

  // Tag of the read currently in flight in the memory
  logic            r_inflight;
  logic [XLEN-1:0] r_if_pc;
  logic            r_if_epoch;

  // Two-entry circular skid buffer
  logic [XLEN-1:0] r_buf_pc   [0:1];
  logic [31:0]     r_buf_inst [0:1];
  logic            r_head;
  logic [1:0]      r_count;

  logic            w_run;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_occ;
  logic            w_issue;
  logic            w_misalign;
  logic            w_wr_idx;

  assign w_run      = (r_state == S_RUN);
  assign w_pop      = d_valid && d_ready;
  // A response is only kept when it was fetched in the current epoch.
  assign w_push     = r_inflight && (r_if_epoch == r_epoch);
  assign w_misalign = (redirect_pc[1:0] != 2'b00);

  // Occupancy seen by the issue rule counts the slot freed by a same-cycle
  // pop, which is what allows one fetch per cycle while decode keeps up.
  // Entries plus the in-flight read never exceed 2, so the buffer cannot
  // overflow.
  assign w_occ   = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue = !reset && w_run && !redirect_valid && (w_occ < 3'd2);

  // Tail slot: head + count (mod 2). A push with count=2 cannot occur.
  assign w_wr_idx = r_head ^ r_count[0];

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;
  assign f_pc      = r_pc;
  assign d_valid   = (r_count != 2'd0);
  assign d_pc      = r_buf_pc[r_head];
  assign d_inst    = r_buf_inst[r_head];
  assign fault     = (r_state == S_HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_epoch       <= 1'b0;
      r_inflight    <= 1'b0;
      r_if_pc       <= '0;
      r_if_epoch    <= 1'b0;
      r_buf_pc[0]   <= '0;
      r_buf_pc[1]   <= '0;
      r_buf_inst[0] <= '0;
      r_buf_inst[1] <= '0;
      r_head        <= 1'b0;
      r_count       <= 2'd0;
    end else if (r_state == S_HALT) begin
      // Frozen until reset; redirects are ignored and nothing is fetched.
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else if (redirect_valid) begin
      // Redirect wins over any same-cycle push or pop. Toggling the epoch
      // marks any read issued before this edge as stale.
      r_pc       <= redirect_pc;
      r_epoch    <= ~r_epoch;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      if (w_misalign) begin
        r_state <= S_HALT;
      end
    end else begin
      if (w_push) begin
        r_buf_pc[w_wr_idx]   <= r_if_pc;
        r_buf_inst[w_wr_idx] <= imem_rdata;
      end
      r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_head     <= r_head ^ w_pop;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_pc    <= r_pc;
        r_if_epoch <= r_epoch;
        r_pc       <= r_pc + XLEN'(4);
      end
    end
  end

endmodule
